// File: rtl/line_buffer_ctrl.sv
// Raster sequencer for the 3x3 conv line buffer: walks the zero-padded frame, fetches
// interior pixels from RAM and tags valid windows. Define LB_CTRL_WINCNT_EN for win_cnt.
module line_buffer_ctrl #(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224,
    parameter int DW    = 9,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] lb_d,
    output logic          win_valid,
    output logic [15:0]   win_row,
    output logic [15:0]   win_col,
    output logic          busy,
`ifdef LB_CTRL_WINCNT_EN
    output logic          done,
    output logic [31:0]   win_cnt
`else
    output logic          done
`endif
);
    localparam int PW = IMG_W + 2;
    localparam int PH = IMG_H + 2;
    localparam int STAGES = 3;
    localparam logic [15:0] LAST_C = 16'(PW - 1);
    localparam logic [15:0] LAST_R = 16'(PH - 1);
    localparam logic [15:0] MAX_C  = 16'(IMG_W);
    localparam logic [15:0] MAX_R  = 16'(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   r_q, r_d, c_q, c_d;
    logic [AW-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
    logic [1:0]    drn_q, drn_d;
    logic          pix_vld_q, pix_vld_d;
    logic [STAGES:1]              vld_pipe_q, vld_pipe_d;
    logic [STAGES-1:1][15:0]      row_pipe_q, row_pipe_d, col_pipe_q, col_pipe_d;
    logic [15:0]   win_row_q, win_row_d, win_col_q, win_col_d;
    logic          interior, at_last, feed_go;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        drn_d       = drn_q;
        feed_go     = 1'b0;
        interior    = (state_q == S_FEED) && (r_q != 16'd0) && (r_q <= MAX_R)
                      && (c_q != 16'd0) && (c_q <= MAX_C);
        at_last     = (r_q == LAST_R) && (c_q == LAST_C);

        case (state_q)
            S_IDLE: feed_go = start;
            S_FEED: begin
                if (c_q == LAST_C) begin
                    c_d = 16'd0;
                    r_d = at_last ? 16'd0 : r_q + 16'd1;
                end else begin
                    c_d = c_q + 16'd1;
                end
                // Address counter walks only interior pixels, so no (r-1)*W product is needed.
                if (interior) begin
                    addr_d      = addr_q + AW'(1);
                    last_addr_d = addr_q;
                end
                if (at_last) begin
                    state_d = S_DRAIN;
                    drn_d   = 2'd0;
                end
            end
            S_DRAIN: begin
                drn_d = drn_q + 2'd1;
                if (drn_q == 2'd2) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                feed_go = start;
            end
            default: state_d = S_IDLE;
        endcase

        if (feed_go) begin
            state_d     = S_FEED;
            r_d         = 16'd0;
            c_d         = 16'd0;
            addr_d      = '0;
            last_addr_d = '0;
        end

        pix_vld_d     = interior;
        vld_pipe_d[1] = (state_q == S_FEED) && (r_q > 16'd1) && (c_q > 16'd1);
        row_pipe_d[1] = r_q - 16'd2;
        col_pipe_d[1] = c_q - 16'd2;
        for (int i = 2; i <= STAGES; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
        for (int i = 2; i < STAGES; i++) begin
            row_pipe_d[i] = row_pipe_q[i-1];
            col_pipe_d[i] = col_pipe_q[i-1];
        end
        // Tag outputs only move on a valid window and otherwise keep the last one.
        win_row_d = vld_pipe_q[STAGES-1] ? row_pipe_q[STAGES-1] : win_row_q;
        win_col_d = vld_pipe_q[STAGES-1] ? col_pipe_q[STAGES-1] : win_col_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            c_q         <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            drn_q       <= '0;
            pix_vld_q   <= 1'b0;
            vld_pipe_q  <= '0;
            row_pipe_q  <= '0;
            col_pipe_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            drn_q       <= drn_d;
            pix_vld_q   <= pix_vld_d;
            vld_pipe_q  <= vld_pipe_d;
            row_pipe_q  <= row_pipe_d;
            col_pipe_q  <= col_pipe_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign mem_rd    = interior;
    assign mem_addr  = interior ? addr_q : last_addr_q;
    assign lb_d      = pix_vld_q ? mem_rdata : '0;
    assign win_valid = vld_pipe_q[STAGES];
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

`ifdef LB_CTRL_WINCNT_EN
    logic [31:0] win_cnt_q, win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (feed_go)        win_cnt_d = 32'd0;
        else if (win_valid) win_cnt_d = win_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) win_cnt_q <= '0;
        else     win_cnt_q <= win_cnt_d;
    end

    assign win_cnt = win_cnt_q;
`endif
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for the 3×3 convolution line buffer. It walks a zero-padded (IMG_H+2)×(IMG_W+2) frame in raster order. It reads interior pixels from a synchronous feature-map RAM and drives the line buffer's `D` input with one pixel per clock. It also flags the cycles in which the line buffer's `conv1..conv9` outputs hold a valid 3×3 window, tagged with output row and column. It sits between the feature-map RAM and the line buffer, upstream of the MAC array.

## Interface
Parameters:
- `IMG_W`, default 224: unpadded image width.
- `IMG_H`, default 224: unpadded image height.
- `DW`, default 9: pixel width; must equal the line buffer `D` width.
- `AW`, default 16: RAM address width; must satisfy 2^AW ≥ IMG_W·IMG_H.

Ports (clock and reset first):
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: frame request; sampled only while `busy`=0.
- `mem_rd` out, 1: RAM read strobe.
- `mem_addr` out, AW: RAM address.
- `mem_rdata` in, DW: RAM data, valid the cycle after `mem_rd`.
- `lb_d` out, DW: drives line buffer `D`.
- `win_valid` out, 1: line buffer `conv1..9` hold a valid window this cycle.
- `win_row` out, 16: output row of the current window.
- `win_col` out, 16: output column of the current window.
- `busy` out, 1: frame in progress.
- `done` out, 1: one-cycle end-of-frame pulse.

## Operation
- Derived constants: PW = IMG_W+2, PH = IMG_H+2, N = PW·PH.
- States:
  - IDLE: entered on reset. Moves to FEED at the edge where `start`=1.
  - FEED: lasts N cycles. Moves to DRAIN after padded index k = N−1.
  - DRAIN: lasts exactly 3 cycles, then moves to DONE.
  - DONE: lasts 1 cycle, then moves to IDLE.
- Counters r (0..PH−1) and c (0..PW−1) are zeroed on entry to FEED. c increments every FEED cycle; when c reaches PW−1 it wraps to 0 and r increments.
- A pixel is interior when 1 ≤ r ≤ IMG_H and 1 ≤ c ≤ IMG_W.
- In FEED cycle k:
  - `mem_rd` = interior.
  - `mem_addr` = (r−1)·IMG_W + (c−1), produced by an incrementing address counter with no multiplier. The counter advances only on interior cycles and clears on FEED entry.
  - Outside interior cycles `mem_addr` holds its last value.
- A pad flag is delayed 1 cycle. In the following cycle, `lb_d` = `mem_rdata` when the delayed flag marks an interior pixel, otherwise 0. `lb_d` is 0 in IDLE, DONE and the DRAIN cycles that carry no FEED pixel.
- The window tag is {r≥2 && c≥2, r−2, c−2}. It is delayed 3 cycles and drives `win_valid`, `win_row` and `win_col`.
- Line buffer contents left over from a previous frame need no clearing. The first valid window, at padded (2,2), is preceded by 454 freshly fed pixels.
- Windows per frame: exactly IMG_H·IMG_W. They are emitted in row-major order. Row r has PW−IMG_W = 2 invalid cycles, at its first two columns.
- `start` is ignored while `busy`=1. `start` held high across DONE begins the next frame in the cycle after DONE.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `lb_d`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `busy`=0, `done`=0. State resets to IDLE. All counters and delay stages reset to 0.
- If `start` is seen at edge e, FEED cycle k=0 is the cycle after e.
- Per-pixel latency:
  - Pixel k: RAM read in cycle k.
  - `lb_d` valid in cycle k+1.
  - Window with pixel k as `conv9` is flagged in cycle k+3.
- `busy`=1 from FEED cycle 0 through cycle N+2, the last DRAIN cycle.
- `done`=1 in cycle N+3, with `busy`=0 in that cycle.
- `win_row` and `win_col` hold their last values when `win_valid`=0.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). No `done` pulse is produced, and a fresh `start` is required.

## Configuration
- `LB_CTRL_WINCNT_EN` defined:
  - Adds output `win_cnt` [31:0], the number of windows emitted in the current frame.
  - Cleared on FEED entry; increments on each `win_valid` cycle.
  - Holds its value after `done`; reset value 0.
- `LB_CTRL_WINCNT_EN` undefined: the port and its counter are absent, and all other behaviour is identical.

## Test plan
The bench uses IMG_W=4, IMG_H=3 (PW=6, N=30) and a behavioural line buffer of depth 2·PW+3 = 15. RAM word i holds value i+1.
- Reset, then `start` pulse → `mem_rd` first high at k=7 with `mem_addr`=0 → `win_valid` first high at k+3 = cycle 17, with `win_row`=0, `win_col`=0 and window values {0,0,0,0,1,2,0,5,6}.
- Full frame → exactly 12 `win_valid` cycles, with (row, col) from (0,0) to (2,3) in raster order. The final window center is RAM value 12 (`conv5`=12). `done` is high in cycle 33, `busy` in cycles 0–32.
- `start` held high continuously → it is ignored during the frame, and the second frame's FEED k=0 is cycle 34. Second-frame windows match the first exactly, with no stale data.
- `rst` asserted in cycle 20 → all outputs are 0 in the same cycle and no `done` pulse occurs. The next `start` reproduces the first scenario.
- RAM returning 9'h1FF everywhere → padded positions still give `lb_d`=0. The window at (0,0) has `conv1`, `conv2`, `conv3`, `conv4` and `conv7` equal to 0 and all others equal to 9'h1FF.
- With `LB_CTRL_WINCNT_EN` → `win_cnt`=12 at `done`, and it clears to 0 on the next FEED entry.
